// File: rtl/nano_pkg.sv
// nano_pkg: shared NanoCPU memory-system types and widths.
package nano_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    localparam int NANO_AW = 8;
    localparam int NANO_DW = 16;
endpackage

// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter: round-robin, burst-limited arbiter sharing one async-read memory between
// the NanoCPU (M0) and a host/DMA loader (M1).
module nano_mem_arbiter
    import nano_pkg::*;
#(
    parameter int AW       = NANO_AW,
    parameter int DW       = NANO_DW,
    parameter int HOLD_MAX = 4
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(HOLD_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);

    arb_state_t    r_state, w_next;
    logic          r_last_owner;
    logic [CW-1:0] r_burst_cnt;
    logic          w_cap;

    // The counter saturates at LAST, so a long lone burst still yields at once on contention.
    assign w_cap = r_burst_cnt == LAST;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (m0_req && m1_req) ? (r_last_owner ? OWN0 : OWN1) :
                              m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
            OWN0:    w_next = !m0_req ? (m1_req ? OWN1 : IDLE) : (m1_req && w_cap) ? OWN1 : OWN0;
            OWN1:    w_next = !m1_req ? (m0_req ? OWN0 : IDLE) : (m0_req && w_cap) ? OWN0 : OWN1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != IDLE && w_next != r_state) begin
                r_burst_cnt  <= '0;
                r_last_owner <= w_next == OWN1;
            end else if (w_next != IDLE && !w_cap) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    assign m0_gnt   = r_state == OWN0;
    assign m1_gnt   = r_state == OWN1;
    assign m0_rdata = m0_gnt ? mem_rdata : '0;
    assign m1_rdata = m1_gnt ? mem_rdata : '0;

    always_comb begin
        mem_ce    = m0_gnt ? m0_req : m1_gnt ? m1_req : 1'b0;
        mem_we    = m0_gnt ? (m0_req & m0_we) : m1_gnt ? (m1_req & m1_we) : 1'b0;
        mem_addr  = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
        mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
    end
endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb_nano_mem_arbiter: directed checks of reset, lone access, contention, handoff and
// mid-write reset, plus a HOLD_MAX=1 instance for strict alternation.
module tb_nano_mem_arbiter;
    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, mem_ce, mem_we;
    logic [15:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic        h1_m0_gnt, h1_m1_gnt, h1_mem_ce, h1_mem_we;
    logic [15:0] h1_m0_rdata, h1_m1_rdata, h1_mem_wdata;
    logic [7:0]  h1_mem_addr;
    logic        ld = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem [256];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 ck = ~ck;

    always @(posedge ck) begin
        if (ld) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    nano_mem_arbiter u_dut (
        .ck(ck), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    nano_mem_arbiter #(.HOLD_MAX(1)) u_dut_h1 (
        .ck(ck), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(h1_m0_gnt), .m0_rdata(h1_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(h1_m1_gnt), .m1_rdata(h1_m1_rdata),
        .mem_ce(h1_mem_ce), .mem_we(h1_mem_we), .mem_addr(h1_mem_addr),
        .mem_wdata(h1_mem_wdata), .mem_rdata(16'h0000)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        @(negedge ck);
        ld = 1'b1; ld_addr = a; ld_data = d;
        @(negedge ck);
        ld = 1'b0;
    endtask

    initial begin
        logic exp0;
        #1 rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'h05; m1_addr = 8'h06;
        load(8'h05, 16'hAAAA);
        load(8'h06, 16'hBBBB);
        load(8'h20, 16'h0BAD);
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_mem_ce", 32'(mem_ce), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(negedge ck);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ck);
            exp0 = (k < 4) || (k >= 8);
            check($sformatf("cont_m0_gnt[%0d]", k), 32'(m0_gnt), 32'(exp0));
            check($sformatf("cont_m1_gnt[%0d]", k), 32'(m1_gnt), 32'(!exp0));
            check($sformatf("cont_m0_rdata[%0d]", k), 32'(m0_rdata), exp0 ? 32'hAAAA : 32'h0);
            check($sformatf("cont_m1_rdata[%0d]", k), 32'(m1_rdata), exp0 ? 32'h0 : 32'hBBBB);
            check($sformatf("h1_alt_m0_gnt[%0d]", k), 32'(h1_m0_gnt), 32'(k % 2 == 0));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge ck);
        check("idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h10; m1_wdata = 16'h1234;
        @(negedge ck);
        check("wr_m1_gnt", 32'(m1_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'h10);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        @(negedge ck);
        m1_we = 1'b0;
        #1;
        check("rd_m1_rdata", 32'(m1_rdata), 32'h1234);
        check("rd_m0_rdata", 32'(m0_rdata), 32'h0);
        check("h1_lone_hold", 32'(h1_m1_gnt), 32'd1);
        m1_req = 1'b0;
        @(negedge ck);
        check("idle2_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 16'h1111;
        @(negedge ck);
        check("ho_m0_gnt", 32'(m0_gnt), 32'd1);
        check("ho_mem_we", 32'(mem_we), 32'd1);
        @(negedge ck);
        m0_req = 1'b0; m0_wdata = 16'h2222;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h30;
        #1;
        check("drop_m0_gnt", 32'(m0_gnt), 32'd1);
        check("drop_mem_ce", 32'(mem_ce), 32'd0);
        check("drop_mem_we", 32'(mem_we), 32'd0);
        @(negedge ck);
        check("ho_m1_gnt", 32'(m1_gnt), 32'd1);
        check("ho_m0_gnt_off", 32'(m0_gnt), 32'd0);
        check("ho_m1_rdata", 32'(m1_rdata), 32'h1111);
        m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 16'hDEAD;
        #1;
        check("mr_pre_mem_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mr_m1_gnt", 32'(m1_gnt), 32'd0);
        check("mr_mem_we", 32'(mem_we), 32'd0);
        check("mr_mem_ce", 32'(mem_ce), 32'd0);
        @(negedge ck);
        check("mr_mem20", 32'(mem[8'h20]), 32'h0BAD);
        m1_we = 1'b0; m0_req = 1'b1;
        rst = 1'b1;
        @(negedge ck);
        check("mr_restart_m0", 32'(m0_gnt), 32'd1);
        check("mr_restart_m1", 32'(m1_gnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
